data_memory_unit: RTL and testbench
===================================

Name: data_memory_unit

Overview:
- Handshaked 16x8 data memory that sits directly downstream of the accumulator CPU's data port.
- Consumes the CPU's mReadFlag, mWriteFlag, dataMemAddrBus and dataMemInDataBus, and returns dataMemOutDataBus.
- Each access takes a fixed multi-cycle sequence. mem_ready marks completion so the control unit can stall.
- A preload port lets the bench or a boot sequencer initialise contents while the unit is idle.

Parameters:
DATA_WIDTH, 8, width of each memory word and of the data buses
ADDR_WIDTH, 4, address width
DEPTH, 16, number of words (must equal 2**ADDR_WIDTH)

Ports:
clock  input  1  single system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
mReadFlag  input  1  read request from CPU; sampled in IDLE only
mWriteFlag  input  1  write request from CPU; sampled in IDLE only
dataMemAddrBus  input  ADDR_WIDTH  access address; captured with the request
dataMemInDataBus  input  DATA_WIDTH  write data from CPU; captured with a write request
dataMemOutDataBus  output  DATA_WIDTH  registered read data; holds last read value
mem_ready  output  1  one-cycle pulse when an access completes
mem_busy  output  1  high while state != IDLE
access_err  output  1  sticky flag: read and write were requested in the same cycle
load_en  input  1  preload strobe; honoured only in IDLE with no CPU request
load_addr  input  ADDR_WIDTH  preload address
load_data  input  DATA_WIDTH  preload data

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all 16 words cleared to 0x00.
  - dataMemOutDataBus=0x00, mem_ready=0, mem_busy=0, access_err=0.
  - Latched address, data and operation are cleared.
  - Reset asserted mid-access aborts that access. An in-flight write must not modify the array.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - mWriteFlag=1: latch address and data, op=WRITE, go to ACCESS.
  - mReadFlag=1 with mWriteFlag=0: latch address, op=READ, go to ACCESS.
  - Both flags=1: treat as WRITE and set access_err=1. access_err stays set until reset.
  - No request and load_en=1: write mem[load_addr]=load_data at this edge and stay in IDLE. mem_ready is not pulsed.
  - CPU request and load_en=1 in the same cycle: the CPU request wins; the load is dropped.
- ACCESS (exactly 1 cycle):
  - WRITE: mem[addr]<=data.
  - READ: dataMemOutDataBus<=mem[addr].
  - Next state is DONE.
- DONE (exactly 1 cycle): mem_ready=1, then go to IDLE. Requests are ignored while busy.
- Timing:
  - Request sampled at edge N.
  - Read data is valid on dataMemOutDataBus after edge N+1.
  - mem_ready is high during the cycle following edge N+1; state leaves DONE at edge N+2.
  - Minimum spacing between back-to-back accepted requests: 3 cycles (request is re-sampled in IDLE at edge N+3).
- mem_busy=1 in ACCESS and DONE; mem_busy=0 in IDLE. Outputs are registered or decoded from state only, with no combinational path from inputs.
- Reads never alter memory. Writes never alter dataMemOutDataBus.
- Read after write to the same address returns the new value.
- Addresses cover all 16 locations; there is no wrap or out-of-range case.
- Flags held high across DONE are re-accepted as a new request in the following IDLE cycle. The CPU drops its flag when it sees mem_ready.

Test Plan:
- Reset and default read:
  - Stimulus: assert reset=0 mid-write, release, then read address 0x5.
  - Required response: mem_busy=0 and outputs 0 during reset; the read returns 0x00 with mem_ready after 2 cycles; the aborted write is absent.
- Preload then read:
  - Stimulus: load_en with load_addr=0x3, load_data=0xA7; then mReadFlag with address 0x3.
  - Required response: dataMemOutDataBus=0xA7 one edge after acceptance; mem_ready pulses exactly one cycle.
- Write then read back:
  - Stimulus: write 0x5C to 0xF, then read 0xF; repeat at 0x0.
  - Required response: both reads return 0x5C; dataMemOutDataBus is unchanged across each write.
- Busy handling:
  - Stimulus: hold mReadFlag for 6 cycles with address 0x2, and pulse load_en during ACCESS.
  - Required response: exactly two accesses complete, at edges N+2 and N+5; the load is ignored; mem[0x2] is unchanged.
- Conflict:
  - Stimulus: mReadFlag=1 and mWriteFlag=1 together, address 0x7, data 0x11.
  - Required response: mem[0x7]=0x11; access_err=1 and it remains 1 through later clean accesses until reset.
- Load/request collision:
  - Stimulus: in IDLE, load_en to 0x4 with 0xEE in the same cycle as a write of 0x22 to 0x4.
  - Required response: a subsequent read of 0x4 returns 0x22.

Source files
------------

// File: rtl/data_memory_unit.sv
// data_memory_unit
// Handshaked 16x8 data memory placed behind the accumulator CPU data port.
// Every CPU access runs IDLE -> ACCESS -> DONE. mem_ready pulses in DONE so
// the control unit can stall. A preload port writes words while the unit is
// idle and no CPU request is present.
module data_memory_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mReadFlag,
  input  logic                  mWriteFlag,
  input  logic [ADDR_WIDTH-1:0] dataMemAddrBus,
  input  logic [DATA_WIDTH-1:0] dataMemInDataBus,
  output logic [DATA_WIDTH-1:0] dataMemOutDataBus,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  access_err,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Architectural state
  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_op;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Combinational control
  logic [1:0]            w_next_state;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_conflict;
  logic                  w_load_fire;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign w_req       = mReadFlag | mWriteFlag;
  // A CPU request always beats a preload issued in the same cycle.
  assign w_load_fire = (r_state == ST_IDLE) & ~w_req & load_en;

  // Next-state decode: requests are only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_conflict   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_conflict   = mReadFlag & mWriteFlag;
          w_next_state = ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS: w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Array write port: either the latched CPU write in ACCESS or an idle preload.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_addr;
    w_mem_wdata = r_data;
    if ((r_state == ST_ACCESS) && (r_op == OP_WRITE)) begin
      w_mem_we = 1'b1;
    end else if (w_load_fire) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = load_addr;
      w_mem_wdata = load_data;
    end else begin
      w_mem_we = 1'b0;
    end
  end

  // State register plus the request latch captured on acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_data  <= {DATA_WIDTH{1'b0}};
      r_op    <= OP_READ;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr <= dataMemAddrBus;
        // A simultaneous read+write is resolved as a write.
        if (mWriteFlag) begin
          r_op   <= OP_WRITE;
          r_data <= dataMemInDataBus;
        end else begin
          r_op   <= OP_READ;
        end
      end
    end
  end

  // Storage array; reset clears every word, so an aborted write never lands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Read data register: only a READ in ACCESS updates it, so writes leave it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dout <= {DATA_WIDTH{1'b0}};
    end else if ((r_state == ST_ACCESS) && (r_op == OP_READ)) begin
      r_dout <= r_mem[r_addr];
    end
  end

  // Handshake flags registered from next state so they track the FSM exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ready <= (w_next_state == ST_DONE);
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_conflict) begin
      r_err <= 1'b1;
    end
  end

  assign dataMemOutDataBus = r_dout;
  assign mem_ready         = r_ready;
  assign mem_busy          = r_busy;
  assign access_err        = r_err;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit.
module tb_data_memory_unit;

  logic       clock;
  logic       reset;
  logic       mReadFlag;
  logic       mWriteFlag;
  logic [3:0] dataMemAddrBus;
  logic [7:0] dataMemInDataBus;
  logic [7:0] dataMemOutDataBus;
  logic       mem_ready;
  logic       mem_busy;
  logic       access_err;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;

  int total_cnt;
  int bad_cnt;
  logic [7:0] exp_dout;

  data_memory_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut (
    .clock             (clock),
    .reset             (reset),
    .mReadFlag         (mReadFlag),
    .mWriteFlag        (mWriteFlag),
    .dataMemAddrBus    (dataMemAddrBus),
    .dataMemInDataBus  (dataMemInDataBus),
    .dataMemOutDataBus (dataMemOutDataBus),
    .mem_ready         (mem_ready),
    .mem_busy          (mem_busy),
    .access_err        (access_err),
    .load_en           (load_en),
    .load_addr         (load_addr),
    .load_data         (load_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    mReadFlag        = 1'b0;
    mWriteFlag       = 1'b0;
    load_en          = 1'b0;
  endtask

  // One full access: accept edge, ACCESS edge, DONE edge.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [3:0] addr, input logic [7:0] data,
                           input logic [7:0] exp_rd, input logic exp_err);
    mReadFlag        = rd;
    mWriteFlag       = wr;
    dataMemAddrBus   = addr;
    dataMemInDataBus = data;
    step();
    idle_inputs();
    chk({tag, "_busy_acc"}, mem_busy, 1'b1);
    chk({tag, "_rdy_acc"}, mem_ready, 1'b0);
    step();
    if (rd && !wr) exp_dout = exp_rd;
    chk({tag, "_rdy_done"}, mem_ready, 1'b1);
    chk({tag, "_busy_done"}, mem_busy, 1'b1);
    chk({tag, "_dout"}, dataMemOutDataBus, exp_dout);
    step();
    chk({tag, "_rdy_idle"}, mem_ready, 1'b0);
    chk({tag, "_busy_idle"}, mem_busy, 1'b0);
    chk({tag, "_err"}, access_err, exp_err);
  endtask

  task automatic preload(input logic [3:0] addr, input logic [7:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    step();
    load_en = 1'b0;
    chk("load_no_rdy", mem_ready, 1'b0);
    chk("load_no_busy", mem_busy, 1'b0);
  endtask

  initial begin
    int rdy_cnt;
    logic [7:0] rdy_mask;
    total_cnt = 0;
    bad_cnt   = 0;
    exp_dout  = 8'h00;
    reset            = 1'b0;
    idle_inputs();
    dataMemAddrBus   = 4'h0;
    dataMemInDataBus = 8'h00;
    load_addr        = 4'h0;
    load_data        = 8'h00;

    // Reset state
    repeat (2) step();
    chk("rst_busy", mem_busy, 1'b0);
    chk("rst_rdy", mem_ready, 1'b0);
    chk("rst_dout", dataMemOutDataBus, 8'h00);
    chk("rst_err", access_err, 1'b0);
    reset = 1'b1;
    step();

    // Write aborted by reset in ACCESS
    mWriteFlag       = 1'b1;
    dataMemAddrBus   = 4'h5;
    dataMemInDataBus = 8'h99;
    step();
    idle_inputs();
    chk("abort_busy_pre", mem_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", mem_busy, 1'b0);
    chk("abort_rdy", mem_ready, 1'b0);
    chk("abort_dout", dataMemOutDataBus, 8'h00);
    step();
    reset = 1'b1;
    step();
    do_access("rd5", 1'b1, 1'b0, 4'h5, 8'h00, 8'h00, 1'b0);

    // Preload then read
    preload(4'h3, 8'hA7);
    do_access("rd3", 1'b1, 1'b0, 4'h3, 8'h00, 8'hA7, 1'b0);

    // Write then read back; dout must hold across each write
    do_access("wrF", 1'b0, 1'b1, 4'hF, 8'h5C, 8'h00, 1'b0);
    do_access("rdF", 1'b1, 1'b0, 4'hF, 8'h00, 8'h5C, 1'b0);
    preload(4'h1, 8'h61);
    do_access("rd1", 1'b1, 1'b0, 4'h1, 8'h00, 8'h61, 1'b0);
    do_access("wr0", 1'b0, 1'b1, 4'h0, 8'h5C, 8'h00, 1'b0);
    do_access("rd0", 1'b1, 1'b0, 4'h0, 8'h00, 8'h5C, 1'b0);

    // Busy handling: read held 6 edges, load pulsed during ACCESS
    preload(4'h2, 8'h3C);
    rdy_cnt  = 0;
    rdy_mask = 8'h00;
    dataMemAddrBus = 4'h2;
    for (int k = 0; k < 8; k++) begin
      mReadFlag = (k < 6);
      load_en   = (k == 1);
      load_addr = 4'h2;
      load_data = 8'hFF;
      step();
      if (mem_ready) begin
        rdy_cnt++;
        rdy_mask[k] = 1'b1;
      end
    end
    idle_inputs();
    chk("busy_rdy_count", rdy_cnt, 2);
    chk("busy_rdy_mask", rdy_mask, 8'h12);
    chk("busy_dout", dataMemOutDataBus, 8'h3C);
    exp_dout = 8'h3C;
    preload(4'h9, 8'h00);
    do_access("rd9", 1'b1, 1'b0, 4'h9, 8'h00, 8'h00, 1'b0);
    do_access("rd2", 1'b1, 1'b0, 4'h2, 8'h00, 8'h3C, 1'b0);

    // Conflict: read+write together acts as write and sets sticky error
    do_access("conf", 1'b1, 1'b1, 4'h7, 8'h11, 8'h00, 1'b1);
    do_access("rd7", 1'b1, 1'b0, 4'h7, 8'h00, 8'h11, 1'b1);

    // Load/request collision: CPU write wins
    load_en   = 1'b1;
    load_addr = 4'h4;
    load_data = 8'hEE;
    do_access("coll", 1'b0, 1'b1, 4'h4, 8'h22, 8'h00, 1'b1);
    do_access("rd4", 1'b1, 1'b0, 4'h4, 8'h00, 8'h22, 1'b1);

    // Reset clears the sticky error and the array
    reset = 1'b0;
    step();
    chk("rst2_err", access_err, 1'b0);
    chk("rst2_dout", dataMemOutDataBus, 8'h00);
    reset    = 1'b1;
    exp_dout = 8'h00;
    step();
    do_access("rd7_clr", 1'b1, 1'b0, 4'h7, 8'h00, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
